// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes and FSM encoding for the multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 mult/div with HI/LO; latency NBITS+1 (div-by-zero 1, MTHI/MTLO 0).
// Backpressure: start is only taken while busy=0; a start during an operation is dropped.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_control,
  input  logic [NBITS-1:0] operando_A,
  input  logic [NBITS-1:0] operando_B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [NBITS-1:0] hi,
  output logic [NBITS-1:0] lo
);

  localparam int CW = $clog2(NBITS);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [NBITS-1:0]   hi_q, hi_d;
  logic [NBITS-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               sgn_a, sgn_b;
  logic [NBITS-1:0]   mag_a, mag_b;
  logic [NBITS:0]     mul_sum;
  logic [NBITS:0]     div_shift;
  logic               div_ge;
  logic [NBITS-1:0]   div_rem;
  logic [2*NBITS-1:0] prod;

  function automatic logic [NBITS-1:0] mag(input logic [NBITS-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    // Bit 0 of the opcode selects the unsigned variant of MULT/DIV.
    sgn_a = ~md_control[0] & operando_A[NBITS-1];
    sgn_b = ~md_control[0] & operando_B[NBITS-1];
    mag_a = mag(operando_A, sgn_a);
    mag_b = mag(operando_B, sgn_b);

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    mul_sum = acc_q[0] ? ({1'b0, acc_q[2*NBITS-1:NBITS]} + {1'b0, opnd_q})
                       : {1'b0, acc_q[2*NBITS-1:NBITS]};
    // Divide: accumulator is {partial remainder, dividend shifting into quotient}.
    div_shift = {acc_q[2*NBITS-1:NBITS], acc_q[NBITS-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? NBITS'(div_shift - {1'b0, opnd_q}) : div_shift[NBITS-1:0];
    prod      = neg_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (md_control)
            MD_MTHI: begin
              hi_d   = operando_A;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            MD_MTLO: begin
              lo_d   = operando_A;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              dbz_d    = 1'b0;
              is_div_d = md_control[1];
              neg_d    = sgn_a ^ sgn_b;
              rneg_d   = sgn_a;
              cnt_d    = '0;
              if (md_control[1] && (operando_B == '0)) begin
                dz_d    = 1'b1;
                acc_d   = {operando_A, {NBITS{1'b1}}};
                state_d = S_FIX;
              end else begin
                dz_d    = 1'b0;
                opnd_d  = md_control[1] ? mag_b : mag_a;
                acc_d   = {{NBITS{1'b0}}, (md_control[1] ? mag_a : mag_b)};
                state_d = S_CALC;
              end
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = is_div_q ? {div_rem, acc_q[NBITS-2:0], div_ge}
                           : {mul_sum, acc_q[NBITS-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NBITS-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d  = acc_q[2*NBITS-1:NBITS];
            lo_d  = acc_q[NBITS-1:0];
            dbz_d = 1'b1;
          end else if (is_div_q) begin
            lo_d = mag(acc_q[NBITS-1:0], neg_q);
            hi_d = mag(acc_q[2*NBITS-1:NBITS], rneg_q);
          end else begin
            hi_d = prod[2*NBITS-1:NBITS];
            lo_d = prod[NBITS-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops against a 64-bit arithmetic model.
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [2:0]   md_control;
  logic [N-1:0] opa, opb;
  logic         busy, done, dbz;
  logic [N-1:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  mult_div_unit #(.NBITS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .md_control (md_control),
    .operando_A (opa),
    .operando_B (opb),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .div_by_zero(dbz),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_hi", {32'b0, hi}, {32'b0, e.hi});
        check("res_lo", {32'b0, lo}, {32'b0, e.lo});
        check("res_dbz", {63'b0, dbz}, {63'b0, e.dz});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Reference model: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                       output int lat);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx  = $signed(x);
    sy  = $signed(y);
    rh  = m_hi;
    rl  = m_lo;
    rdz = 1'b0;
    lat = N + 1;
    case (op)
      3'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
      3'd2, 3'd3: begin
        if (y == 0) begin
          rh = x; rl = 32'hFFFF_FFFF; rdz = 1'b1; lat = 1;
        end else if (op == 3'd2) begin
          q = sx / sy; r = sx % sy;
          p = 64'(q); rl = p[31:0];
          p = 64'(r); rh = p[31:0];
        end else begin
          rl = x / y; rh = x % y;
        end
      end
      3'd4: begin rh = x; lat = 0; end
      3'd5: begin rl = x; lat = 0; end
      default: lat = 0;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit b2b, input int intrude_at, input int flush_at);
    logic [31:0] rh, rl;
    logic        rdz;
    int          lat, e0, bc, exp_bc;
    bit          finished;
    if (!b2b) @(negedge clk);
    start = 1'b1; md_control = op; opa = x; opb = y;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0; opa = $urandom; opb = $urandom;
    if (op <= 3'd5) begin
      model(op, x, y, rh, rl, rdz, lat);
      if (flush_at < 0) begin
        sb.push_back('{hi: rh, lo: rl, dz: rdz, cyc: e0 + lat});
        m_hi = rh;
        m_lo = rl;
        exp_bc = lat;
      end else begin
        exp_bc = flush_at + 1;
      end
    end else begin
      exp_bc = 0;
    end
    bc = 0;
    finished = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (i == intrude_at);
      if (i == intrude_at) begin
        md_control = 3'($urandom_range(0, 5)); opa = $urandom; opb = $urandom;
      end
      flush = (i == flush_at);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      bc++;
    end
    start = 1'b0;
    flush = 1'b0;
    check("busy_finished", {63'b0, finished}, 64'd1);
    check("busy_cycles", 64'(bc), 64'(exp_bc));
    if (flush_at >= 0) begin
      check("flush_hi_kept", {32'b0, hi}, {32'b0, m_hi});
      check("flush_lo_kept", {32'b0, lo}, {32'b0, m_lo});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; md_control = '0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dbz", {63'b0, dbz}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFD, 32'h7, 1'b0, -1, -1);
    check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'b0, lo}, 64'hFFFF_FFEB);
    do_op(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b1, -1, -1);
    check("multu_hi", {32'b0, hi}, 64'h1);
    check("multu_lo", {32'b0, lo}, 64'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, -1, -1);
    check("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    do_op(3'd3, 32'h7, 32'h2, 1'b0, -1, -1);
    check("divu_lo", {32'b0, lo}, 64'h3);
    check("divu_hi", {32'b0, hi}, 64'h1);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1);
    check("divmin_lo", {32'b0, lo}, 64'h8000_0000);
    check("divmin_hi", {32'b0, hi}, 64'h0);
    do_op(3'd2, 32'h5, 32'h0, 1'b0, -1, -1);
    check("dz_hi", {32'b0, hi}, 64'h5);
    check("dz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
    check("dz_flag", {63'b0, dbz}, 64'd1);
    do_op(3'd5, 32'h0000_ABCD, 32'h0, 1'b0, -1, -1);
    check("mtlo_lo", {32'b0, lo}, 64'hABCD);
    check("mtlo_hi_kept", {32'b0, hi}, 64'h5);
    check("mtlo_dbz", {63'b0, dbz}, 64'd0);
    do_op(3'd4, 32'h1234_5678, 32'h0, 1'b1, -1, -1);
    check("mthi_hi", {32'b0, hi}, 64'h1234_5678);

    do_op(3'd0, 32'h123, 32'h456, 1'b0, 5, -1);
    check("intrude_lo", {32'b0, lo}, 64'h4EDC2);
    do_op(3'd2, $urandom, 32'h3, 1'b0, -1, 9);
    do_op(3'd6, 32'h11, 32'h22, 1'b0, -1, -1);
    do_op(3'd7, 32'h11, 32'h22, 1'b1, -1, -1);

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] x, y;
      op = 3'($urandom_range(0, 5));
      x  = $urandom;
      y  = $urandom;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) x = $urandom_range(0, 40);
      do_op(op, x, y, 1'($urandom_range(0, 1)), -1, -1);
    end

    // Reset in the middle of a multiply, between clock edges.
    @(negedge clk);
    start = 1'b1; md_control = 3'd0; opa = 32'h99; opb = 32'h77;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_dbz", {63'b0, dbz}, 64'd0);
    check("midrst_hi", {32'b0, hi}, 64'd0);
    check("midrst_lo", {32'b0, lo}, 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd0, 32'h6, 32'h7, 1'b0, -1, -1);
    check("postrst_lo", {32'b0, lo}, 64'h2A);
    check("postrst_hi", {32'b0, hi}, 64'h0);

    repeat (5) @(negedge clk);
    check("pending_results", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
